// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source for the VGA output path. Divides Clk down to the pixel
//   rate, scans DrawX/DrawY over the full frame and produces hs, vs, blank,
//   sync and pixel_clk. All raster outputs are registers loaded from a decode
//   of the next counter values, so they are aligned with DrawX/DrawY.
//
//   Optional feature macro: FRAME_STROBE_EN
//     defined   -> frame_start port: 1-Clk pulse when the scan enters (0,V_VISIBLE)
//     undefined -> no frame_start port, no strobe logic
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous active-high reset
//   pixel_clk    out  divided pixel clock, 50% duty
//   hs           out  horizontal sync, active-low
//   vs           out  vertical sync, active-low
//   blank        out  1 = visible region, 0 = blanking
//   sync         out  composite sync, tied 0
//   DrawX        out  current pixel column, 0..H_TOTAL-1
//   DrawY        out  current line, 0..V_TOTAL-1
//   frame_start  out  (FRAME_STROBE_EN) start-of-vertical-blanking strobe
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       Clk,
   input  logic       Reset,
   output logic       pixel_clk,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       sync,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY
`ifdef FRAME_STROBE_EN
   ,
   output logic       frame_start
`endif
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned CNT_W   = 10;
   // Decode compares are one bit wider so a sync window ending at 1024 still works.
   localparam int unsigned CMP_W   = CNT_W + 1;
   localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   localparam logic [CMP_W-1:0] H_VIS_END  = CMP_W'(H_VISIBLE);
   localparam logic [CMP_W-1:0] HS_START   = CMP_W'(H_VISIBLE + H_FRONT);
   localparam logic [CMP_W-1:0] HS_END     = CMP_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CMP_W-1:0] V_VIS_END  = CMP_W'(V_VISIBLE);
   localparam logic [CMP_W-1:0] VS_START   = CMP_W'(V_VISIBLE + V_FRONT);
   localparam logic [CMP_W-1:0] VS_END     = CMP_W'(V_VISIBLE + V_FRONT + V_SYNC);

   // Parameter legality, rejected at elaboration
   generate
      if (H_TOTAL > 1024) begin : g_bad_h_total
         $error("vga_timing_gen: H_TOTAL (%0d) exceeds 1024", H_TOTAL);
      end
      if (V_TOTAL > 1024) begin : g_bad_v_total
         $error("vga_timing_gen: V_TOTAL (%0d) exceeds 1024", V_TOTAL);
      end
      if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_clk_div
         $error("vga_timing_gen: CLK_DIV (%0d) must be even and >= 2", CLK_DIV);
      end
   endgenerate

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_nxt;
   logic             pe;
   logic             pclk_nxt;
   logic [CNT_W-1:0] hc_nxt;
   logic [CNT_W-1:0] vc_nxt;
   logic [CMP_W-1:0] hx;
   logic [CMP_W-1:0] vy;
   logic             hs_nxt;
   logic             vs_nxt;
   logic             blank_nxt;

   // Pixel-enable divider and counter advance
   always_comb begin
      pe       = (div == DIV_LAST);
      div_nxt  = pe ? '0 : div + DIV_W'(1);
      // High for the second half of each pixel, so it falls on the pe edge
      pclk_nxt = (div_nxt >= DIV_HALF);
      hc_nxt   = DrawX;
      vc_nxt   = DrawY;
      if (pe) begin
         if (DrawX == H_LAST) begin
            hc_nxt = '0;
            if (DrawY == V_LAST) begin
               vc_nxt = '0;
            end else begin
               vc_nxt = DrawY + CNT_W'(1);
            end
         end else begin
            hc_nxt = DrawX + CNT_W'(1);
         end
      end
   end

   // Sync/blank decode of the next position, registered alongside the counters
   always_comb begin
      hx        = {1'b0, hc_nxt};
      vy        = {1'b0, vc_nxt};
      hs_nxt    = !((hx >= HS_START) && (hx < HS_END));
      vs_nxt    = !((vy >= VS_START) && (vy < VS_END));
      blank_nxt = (hx < H_VIS_END) && (vy < V_VIS_END);
   end

   // Raster state
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         div       <= '0;
         pixel_clk <= 1'b0;
         DrawX     <= '0;
         DrawY     <= '0;
         hs        <= 1'b1;
         vs        <= 1'b1;
         blank     <= 1'b1;
      end else begin
         div       <= div_nxt;
         pixel_clk <= pclk_nxt;
         DrawX     <= hc_nxt;
         DrawY     <= vc_nxt;
         hs        <= hs_nxt;
         vs        <= vs_nxt;
         blank     <= blank_nxt;
      end
   end

   assign sync = 1'b0;

`ifdef FRAME_STROBE_EN
   localparam logic [CNT_W-1:0] V_BLANK_LINE = CNT_W'(V_VISIBLE);

   logic fs_nxt;

   // Pulse on the pe edge that moves the scan onto (0, V_VISIBLE)
   always_comb begin
      fs_nxt = pe && (hc_nxt == '0) && (vc_nxt == V_BLANK_LINE);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= fs_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances: A with the default 640x480 geometry and CLK_DIV=2, B with a
//   small geometry and CLK_DIV=4 so whole frames fit in a short run. A driver
//   issues random reset/run segments and pushes the expected outputs for each
//   sample point into a queue; a monitor pops and compares. The reference model
//   derives every output from the number of Clk edges since reset release.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   // Geometry of instance B
   localparam int B_DIV = 4;
   localparam int B_HV = 16, B_HF = 3, B_HS = 5, B_HB = 4;
   localparam int B_VV = 10, B_VF = 2, B_VS = 2, B_VB = 3;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   always #5 Clk = ~Clk;

   logic       a_pclk, a_hs, a_vs, a_blank, a_sync, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_pclk, b_hs, b_vs, b_blank, b_sync, b_fs;
   logic [9:0] b_x, b_y;

   vga_timing_gen dut_a (
      .Clk        (Clk),
      .Reset      (Reset),
      .pixel_clk  (a_pclk),
      .hs         (a_hs),
      .vs         (a_vs),
      .blank      (a_blank),
      .sync       (a_sync),
      .DrawX      (a_x),
      .DrawY      (a_y)
`ifdef FRAME_STROBE_EN
      ,
      .frame_start(a_fs)
`endif
   );

   vga_timing_gen #(
      .CLK_DIV  (B_DIV),
      .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
      .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
   ) dut_b (
      .Clk        (Clk),
      .Reset      (Reset),
      .pixel_clk  (b_pclk),
      .hs         (b_hs),
      .vs         (b_vs),
      .blank      (b_blank),
      .sync       (b_sync),
      .DrawX      (b_x),
      .DrawY      (b_y)
`ifdef FRAME_STROBE_EN
      ,
      .frame_start(b_fs)
`endif
   );

`ifndef FRAME_STROBE_EN
   assign a_fs = 1'b0;
   assign b_fs = 1'b0;
`endif

   typedef struct packed {
      logic       pclk;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       sync;
      logic       fs;
      logic [9:0] x;
      logic [9:0] y;
   } smp_t;

   typedef struct packed {
      smp_t a;
      smp_t b;
   } pair_t;

   pair_t q[$];
   int    checks   = 0;
   int    failures = 0;
   int    ta       = 0;   // Clk edges since reset release, instance A
   int    tb_t     = 0;   // Clk edges since reset release, instance B

   // Expected outputs after t Clk edges of free running from reset
   function automatic smp_t model(input int t, input int cd,
                                  input int hv, input int hf, input int hsw, input int hb,
                                  input int vv, input int vf, input int vsw, input int vb);
      smp_t m;
      int ht, vt, p, x, y;
      ht      = hv + hf + hsw + hb;
      vt      = vv + vf + vsw + vb;
      p       = t / cd;
      x       = p % ht;
      y       = (p / ht) % vt;
      m.pclk  = ((t % cd) >= (cd / 2));
      m.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
      m.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
      m.blank = (x < hv) && (y < vv);
      m.sync  = 1'b0;
`ifdef FRAME_STROBE_EN
      m.fs    = (t > 0) && ((t % cd) == 0) && ((p % (ht * vt)) == vv * ht);
`else
      m.fs    = 1'b0;
`endif
      m.x     = 10'(x);
      m.y     = 10'(y);
      return m;
   endfunction

   function automatic pair_t expect_now();
      pair_t e;
      e.a = model(ta, 2, 640, 16, 96, 48, 480, 10, 2, 33);
      e.b = model(tb_t, B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB);
      return e;
   endfunction

   // One Clk of stimulus, issued on the falling edge
   task automatic step(input logic r);
      Reset = r;
      if (r) begin
         ta   = 0;
         tb_t = 0;
      end
      q.push_back(expect_now());      // sample just after this falling edge
      if (!r) begin
         ta   = ta + 1;
         tb_t = tb_t + 1;
      end
      q.push_back(expect_now());      // sample just after the next rising edge
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         step(1'b1);
      end
   endtask

   task automatic do_run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         step(1'b0);
         if (failures > 40) break;
      end
   endtask

   task automatic cmp(input string name, input string ph, input smp_t act, input smp_t exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s@%s t=%0t got pclk=%b hs=%b vs=%b blank=%b sync=%b fs=%b x=%0d y=%0d want pclk=%b hs=%b vs=%b blank=%b sync=%b fs=%b x=%0d y=%0d",
                  name, ph, $time,
                  act.pclk, act.hs, act.vs, act.blank, act.sync, act.fs, act.x, act.y,
                  exp.pclk, exp.hs, exp.vs, exp.blank, exp.sync, exp.fs, exp.x, exp.y);
      end
   endtask

   task automatic pop_and_check(input string ph);
      pair_t e;
      smp_t  act_a, act_b;
      if (q.size() == 0) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL queue@%s t=%0t got empty scoreboard want an entry", ph, $time);
         return;
      end
      e     = q.pop_front();
      act_a = {a_pclk, a_hs, a_vs, a_blank, a_sync, a_fs, a_x, a_y};
      act_b = {b_pclk, b_hs, b_vs, b_blank, b_sync, b_fs, b_x, b_y};
      cmp("dut_a", ph, act_a, e.a);
      cmp("dut_b", ph, act_b, e.b);
   endtask

   // Monitor: falling-edge sample catches asynchronous reset, rising-edge
   // sample checks each registered update
   initial begin
      forever begin
         @(negedge Clk);
         #2;
         pop_and_check("neg");
         @(posedge Clk);
         #1;
         pop_and_check("pos");
      end
   end

   // Driver
   initial begin
      do_reset(2);
      do_run(2200);           // A reaches DrawX=300, DrawY=1
      do_reset(1);
      do_run(6000);           // several A lines, three B frames
      for (int k = 0; k < 4; k++) begin
         if (failures <= 40) begin
            do_reset(int'($urandom_range(1, 3)));
            do_run(int'($urandom_range(300, 2500)));
         end
      end
      @(posedge Clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
